nasti_wrr_arbiter: RTL and testbench
====================================

// Module: nasti_wrr_arbiter
// PURPOSE
//  Weighted round-robin grant scheduler for the N-port NASTI mux AW and AR channels.
//  Holds a registered one-hot grant on one requester for up to weight[p] accepted
//  transactions, then rotates. Stable gnt drives the mux port select; enable gates new grants.
// PARAMETERS
//  N        8  number of requesters (>=2)
//  W_WIDTH  4  width of each per-port weight field
// PORTS
//  clk      in   1            clock, rising edge
//  rstn     in   1            reset, asynchronous, active-low
//  req      in   N            per-port request (e.g. master.aw_valid)
//  accept   in   1            granted request completed handshake this cycle (valid&&ready)
//  enable   in   1            permit NEW grants (e.g. !lock && !table_full)
//  weight   in   N*W_WIDTH    port p weight = weight[p*W_WIDTH +: W_WIDTH]; 0 treated as 1
//  gnt      out  N            one-hot grant, all-zero when idle
//  gnt_idx  out  clog2(N)     binary index of granted port; holds last value when idle
//  gnt_vld  out  1            =|gnt
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, ptr=0, credit=0; async assert, sync release.
//  State: IDLE / GRANT; regs ptr[clog2 N], cur[clog2 N], credit[W_WIDTH].
//  IDLE: if enable && |req, pick first p with req[p] searching ptr,ptr+1..N-1,0..ptr-1;
//   next cycle: GRANT, cur=p, credit=max(weight[p],1). Else remain IDLE. Latency req->gnt = 1 clk.
//  GRANT: gnt=1<<cur, gnt_idx=cur, gnt_vld=1, all outputs decoded from registers only.
//   accept sampled only in GRANT (ignored in IDLE).
//   accept && credit>1 && req[cur] && enable : stay GRANT, credit-=1 (back-to-back, no bubble).
//   accept otherwise                          : IDLE, ptr=(cur+1) mod N.
//   !accept && !req[cur] (requester withdrew) : IDLE, ptr=(cur+1) mod N, credit untouched.
//   !accept && req[cur]                       : hold grant regardless of enable.
//  enable low never revokes a live grant; only blocks new grants and burst continuation.
//  accept and req[cur] drop same cycle: accept counts; transition to IDLE.
//  Grant end always costs exactly one IDLE cycle (gnt=0) before next grant.
//  weight sampled only at grant load; changes mid-burst take effect at next grant.
//  ptr wraps N-1 -> 0; for non-power-of-2 N, index arithmetic wraps modulo N, never yields >=N.
//  No starvation: every requester holding req is granted within N grant periods.
//  Reset mid-GRANT: outputs drop to zero asynchronously; ptr returns to 0.
//  Assertions: $onehot0(gnt); gnt_vld==|gnt; gnt stable while req[cur]&&!accept.
// TESTING
//  1 reset, req=8'h04, weights=1 -> gnt=8'h04 one clk after req, gnt_idx=2; accept -> gnt=0 next clk.
//  2 req=8'hFF held, all weights=1, accept every grant -> grant order 0,1..7,0 each separated by 1 idle clk.
//  3 req=8'h03, weight0=3, weight1=1, accept each grant clk -> 0,0,0,(idle),1,(idle),0,0,0 repeating.
//  4 enable=0 with req=8'h10 -> gnt stays 0; raise enable -> gnt=8'h10 next clk; drop enable mid-burst
//    (weight=4) -> grant held until accept, then IDLE, no new grant while enable=0.
//  5 port 5 granted, deassert req[5] without accept -> IDLE next clk, ptr=6; req=8'h21 -> port 0 granted.
//  6 weight=0 on port 3 treated as 1; assert rstn=0 mid-burst -> gnt=0 immediately, after release
//    req=8'hFF grants port 0 first.

Source files
------------

// File: rtl/nasti_wrr_arbiter.sv
// Weighted round-robin grant scheduler for the NASTI mux AW/AR channels.
// Holds a registered one-hot grant for up to weight[p] accepted beats, then rotates.
module nasti_wrr_arbiter #(
  parameter  int N       = 8,
  parameter  int W_WIDTH = 4,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic                 accept,
  input  logic                 enable,
  input  logic [N*W_WIDTH-1:0] weight,
  output logic [N-1:0]         gnt,
  output logic [IW-1:0]        gnt_idx,
  output logic                 gnt_vld
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [1:0]         r_rst_sync;
  logic [0:0]         r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_cur;
  logic [W_WIDTH-1:0] r_credit;

  logic               w_rst_n;
  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic [W_WIDTH-1:0] w_wt;
  logic [W_WIDTH-1:0] w_load;
  logic [IW-1:0]      w_next_ptr;
  logic               w_burst;

  // Reset asserts immediately but releases synchronously to clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Rotating priority search starting at r_ptr; offset wraps modulo N.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < N; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= N) v_idx = v_idx - N;
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(v_idx);
      end
    end
  end

  assign w_wt       = weight[int'(w_pick)*W_WIDTH +: W_WIDTH];
  assign w_load     = (w_wt == '0) ? W_WIDTH'(1) : w_wt;
  assign w_next_ptr = (r_cur == IW'(N-1)) ? '0 : r_cur + 1'b1;
  assign w_burst    = (r_credit > W_WIDTH'(1)) && req[r_cur] && enable;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_cur    <= '0;
      r_credit <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && w_found) begin
            r_state  <= S_GRANT;
            r_cur    <= w_pick;
            r_credit <= w_load;
          end
        end
        default: begin
          if (accept) begin
            if (w_burst) begin
              r_credit <= r_credit - 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_ptr   <= w_next_ptr;
            end
          end else if (!req[r_cur]) begin
            // Requester withdrew: release without consuming credit.
            r_state <= S_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
      endcase
    end
  end

  assign gnt_vld = (r_state == S_GRANT);
  assign gnt     = gnt_vld ? ({{(N-1){1'b0}}, 1'b1} << r_cur) : '0;
  assign gnt_idx = r_cur;

  a_onehot: assert property (@(posedge clk) disable iff (!w_rst_n) $onehot0(gnt));
  a_vld:    assert property (@(posedge clk) disable iff (!w_rst_n) gnt_vld == (|gnt));
  a_hold:   assert property (@(posedge clk) disable iff (!w_rst_n)
                             (gnt_vld && req[r_cur] && !accept) |=> $stable(gnt));

endmodule

// File: tb/tb_nasti_wrr_arbiter.sv
// Directed-vector bench for nasti_wrr_arbiter (N=8, W_WIDTH=4).
module tb_nasti_wrr_arbiter;

  localparam int N  = 8;
  localparam int WW = 4;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  req;
  logic          accept;
  logic          enable;
  logic [N*WW-1:0] weight;
  logic [N-1:0]  gnt;
  logic [2:0]    gnt_idx;
  logic          gnt_vld;

  int n_checks;
  int n_errors;

  nasti_wrr_arbiter #(.N(N), .W_WIDTH(WW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .accept  (accept),
    .enable  (enable),
    .weight  (weight),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Grant vector plus its valid flag in one go.
  task automatic chk_gnt(input string tag, input logic [N-1:0] exp);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(|exp));
  endtask

  // Advance one cycle; inputs are set and outputs sampled at the falling edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk_gnt("rst_async", '0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    req    = '0;
    accept = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(3);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn   = 1'b0;
    req    = '0;
    accept = 1'b0;
    enable = 1'b1;
    weight = 32'h1111_1111;
    step(3);
    chk_gnt("reset", '0);
    check("reset_idx", 32'(gnt_idx), 32'd0);
    rstn = 1'b1;
    step(3);

    // 1: single requester, one-cycle latency, accept ends grant
    req = 8'h04;
    step();
    chk_gnt("t1_grant", 8'h04);
    check("t1_idx", 32'(gnt_idx), 32'd2);
    accept = 1'b1;
    step();
    chk_gnt("t1_release", '0);
    check("t1_idx_hold", 32'(gnt_idx), 32'd2);
    accept = 1'b0;
    req    = '0;

    // 2: all requesting, weight 1, rotation with one idle cycle between grants
    do_reset();
    req    = 8'hFF;
    accept = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_gnt($sformatf("t2_g%0d", k), 8'(1 << (k % N)));
      step();
      chk_gnt($sformatf("t2_i%0d", k), '0);
    end

    // 3: weight0=3, weight1=1
    do_reset();
    weight = 32'h1111_1113;
    req    = 8'h03;
    accept = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step(); chk_gnt($sformatf("t3_r%0d_a", r), 8'h01);
      step(); chk_gnt($sformatf("t3_r%0d_b", r), 8'h01);
      step(); chk_gnt($sformatf("t3_r%0d_c", r), 8'h01);
      step(); chk_gnt($sformatf("t3_r%0d_i0", r), '0);
      step(); chk_gnt($sformatf("t3_r%0d_p1", r), 8'h02);
      step(); chk_gnt($sformatf("t3_r%0d_i1", r), '0);
    end

    // 4: enable gating; dropping enable mid-burst keeps grant until accept
    do_reset();
    weight = 32'h0004_0000;
    enable = 1'b0;
    accept = 1'b0;
    req    = 8'h10;
    step(3);
    chk_gnt("t4_blocked", '0);
    enable = 1'b1;
    step();
    chk_gnt("t4_grant", 8'h10);
    check("t4_idx", 32'(gnt_idx), 32'd4);
    accept = 1'b1;
    step();
    chk_gnt("t4_burst", 8'h10);
    enable = 1'b0;
    accept = 1'b0;
    step();
    chk_gnt("t4_hold0", 8'h10);
    step();
    chk_gnt("t4_hold1", 8'h10);
    accept = 1'b1;
    step();
    chk_gnt("t4_end", '0);
    accept = 1'b0;
    step(2);
    chk_gnt("t4_no_new", '0);
    enable = 1'b1;

    // 5: withdrawal without accept advances pointer past the withdrawn port
    do_reset();
    weight = 32'h1111_1111;
    req    = 8'h20;
    step();
    chk_gnt("t5_grant5", 8'h20);
    req = 8'h00;
    step();
    chk_gnt("t5_withdraw", '0);
    check("t5_idx_hold", 32'(gnt_idx), 32'd5);
    req = 8'h21;
    step();
    chk_gnt("t5_wrap0", 8'h01);
    accept = 1'b1;
    step();
    chk_gnt("t5_idle", '0);
    step();
    chk_gnt("t5_next5", 8'h20);
    accept = 1'b0;
    req    = '0;
    step();

    // 6: weight 0 acts as 1; async reset mid-burst restarts from port 0
    do_reset();
    weight = 32'h1111_0111;
    req    = 8'h08;
    accept = 1'b1;
    step();
    chk_gnt("t6_grant3", 8'h08);
    step();
    chk_gnt("t6_w0_end", '0);
    weight = 32'h1111_0141;
    req    = 8'h02;
    step();
    chk_gnt("t6_burst_a", 8'h02);
    step();
    chk_gnt("t6_burst_b", 8'h02);
    do_reset();
    req    = 8'hFF;
    accept = 1'b0;
    step();
    chk_gnt("t6_after_rst", 8'h01);
    check("t6_idx", 32'(gnt_idx), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
